edge_filter_counter: RTL and testbench

Downstream consumer of the lab's D flip-flop output. It synchronises the registered `q` stream into its own clock domain, filters out pulses shorter than a programmable number of cycles, and emits one-cycle rise/fall strobes. It also keeps saturating rise/fall event counts. The block gives the unit-delay/setup labs a self-checking observer: it shows how many clean transitions actually reached the next stage.

---
 rtl/edge_filter_counter.sv | 155 +++++++++++++++
 tb/tb_edge_filter_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/edge_filter_counter.sv
// edge_filter_counter
// Observer for an asynchronous single-bit stream. It synchronises `d` into the
// `clk` domain and rejects pulses shorter than FILT_CYCLES sampled cycles. For
// each accepted transition it emits a one-cycle rise/fall strobe. It also keeps
// saturating rise/fall event counts with a sticky overflow flag.
module edge_filter_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             clr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic             ovf
);

    localparam int                FC_W    = $clog2(FILT_CYCLES + 1);
    localparam logic [FC_W-1:0]   FC_ZERO = '0;
    localparam logic [FC_W-1:0]   FC_ONE  = FC_W'(1);
    localparam logic [FC_W-1:0]   FC_LAST = FC_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam bit                FAST    = (FILT_CYCLES == 1);

    typedef enum logic [1:0] {
        S_LOW,
        S_HIGH_PEND,
        S_HIGH,
        S_LOW_PEND
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [FC_W-1:0]        fc_q, fc_d;
    logic                   level_d, rise_d, fall_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: shift `d` in at stage 0, filtered side reads the last stage.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours.
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end

    // FSM state register together with the registered level and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOW;
            fc_q    <= FC_ZERO;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            level   <= level_d;
            rise    <= rise_d;
            fall    <= fall_d;
        end
    end

    // Next-state logic: qualify a new level only after FILT_CYCLES agreeing samples.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_d = state_q;
        fc_d    = fc_q;
        unique case (state_q)
            S_LOW: begin
                if (s) begin
                    // With a one-cycle filter the level could flip on the edge
                    // right after a fall strobe. Detour through the pending state
                    // for one cycle so strobes never land back to back.
                    if (FAST && !fall) begin
                        state_d = S_HIGH;
                        fc_d    = FC_ZERO;
                    end else begin
                        state_d = S_HIGH_PEND;
                        fc_d    = FAST ? FC_ZERO : FC_ONE;
                    end
                end
            end
            S_HIGH_PEND: begin
                if (!s) begin
                    state_d = S_LOW;
                    fc_d    = FC_ZERO;
                end else if (fc_q == FC_LAST) begin
                    state_d = S_HIGH;
                    fc_d    = FC_ZERO;
                end else begin
                    fc_d = fc_q + FC_ONE;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    if (FAST && !rise) begin
                        state_d = S_LOW;
                        fc_d    = FC_ZERO;
                    end else begin
                        state_d = S_LOW_PEND;
                        fc_d    = FAST ? FC_ZERO : FC_ONE;
                    end
                end
            end
            S_LOW_PEND: begin
                if (s) begin
                    state_d = S_HIGH;
                    fc_d    = FC_ZERO;
                end else if (fc_q == FC_LAST) begin
                    state_d = S_LOW;
                    fc_d    = FC_ZERO;
                end else begin
                    fc_d = fc_q + FC_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                fc_d    = FC_ZERO;
            end
        endcase
    end

    // Output logic: the level follows the settled state, and strobes mark its edges.
    always_comb begin
        level_d = (state_d == S_HIGH) || (state_d == S_LOW_PEND);
        rise_d  =  level_d && !level;
        fall_d  = !level_d &&  level;
    end

    // Saturating event counters. A clear wins over a coincident event.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rise_cnt <= '0;
            fall_cnt <= '0;
            ovf      <= 1'b0;
        end else begin
            if (rise_d) begin
                if (rise_cnt == CNT_MAX) ovf      <= 1'b1;
                else                     rise_cnt <= rise_cnt + 1'b1;
            end
            if (fall_d) begin
                if (fall_cnt == CNT_MAX) ovf      <= 1'b1;
                else                     fall_cnt <= fall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_edge_filter_counter.sv
// Directed bench for edge_filter_counter. Inputs change 1 time unit after a
// rising edge. Outputs are sampled at the same point, after the edge has settled.
// Loop index i counts the edge that captures the value of `d` set just before it.
module tb_edge_filter_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d   = 1'b0;
    logic       clr = 1'b0;

    logic       level, rise, fall, ovf;
    logic [7:0] rise_cnt, fall_cnt;
    logic       level_s, rise_s, fall_s, ovf_s;
    logic [2:0] rise_cnt_s, fall_cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    edge_filter_counter dut (
        .clk(clk), .rst(rst), .d(d), .clr(clr),
        .level(level), .rise(rise), .fall(fall),
        .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .ovf(ovf)
    );

    edge_filter_counter #(.CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .d(d), .clr(clr),
        .level(level_s), .rise(rise_s), .fall(fall_s),
        .rise_cnt(rise_cnt_s), .fall_cnt(fall_cnt_s), .ovf(ovf_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; d = 1'b0; clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; d = 1'b1; clr = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_checks++;
            if ({level, rise, fall, ovf, rise_cnt, fall_cnt} !== 20'd0) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got %b/%b/%b/%b/%0d/%0d want all 0",
                         i, level, rise, fall, ovf, rise_cnt, fall_cnt);
            end
        end
        rst = 1'b0;
        // The first edge with rst low captures d, and the rise lands four edges later.
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_checks++;
            if (rise !== (i == 5) || level !== (i >= 5) || rise_cnt !== ((i >= 5) ? 8'd1 : 8'd0)) begin
                n_fail++;
                $display("FAIL reset_release e%0d: rise=%b level=%b cnt=%0d want %b %b %0d",
                         i, rise, level, rise_cnt, (i == 5), (i >= 5), (i >= 5) ? 1 : 0);
            end
        end
    endtask

    task automatic test_clean_toggle();
        reset_dut();
        for (int i = 1; i <= 14; i++) begin
            d = (i <= 6);
            tick();
            n_checks++;
            if (rise !== (i == 5) || fall !== (i == 11) || level !== (i >= 5 && i < 11)) begin
                n_fail++;
                $display("FAIL toggle e%0d: rise=%b fall=%b level=%b want %b %b %b",
                         i, rise, fall, level, (i == 5), (i == 11), (i >= 5 && i < 11));
            end
        end
        n_checks++;
        if (rise_cnt !== 8'd1 || fall_cnt !== 8'd1 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_counts: got %0d/%0d ovf=%b want 1/1 ovf=0", rise_cnt, fall_cnt, ovf);
        end
    endtask

    task automatic test_glitch_filter();
        reset_dut();
        for (int i = 1; i <= 10; i++) begin
            d = (i <= 2);
            tick();
            n_checks++;
            if (rise !== 1'b0 || fall !== 1'b0 || level !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch2 e%0d: rise=%b fall=%b level=%b want 0 0 0", i, rise, fall, level);
            end
        end
        n_checks++;
        if (rise_cnt !== 8'd0 || fall_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL glitch2_counts: got %0d/%0d want 0/0", rise_cnt, fall_cnt);
        end
        // Exactly three sampled cycles high is the shortest accepted pulse.
        for (int i = 1; i <= 12; i++) begin
            d = (i <= 3);
            tick();
            n_checks++;
            if (rise !== (i == 5) || fall !== (i == 8) || level !== (i >= 5 && i < 8)) begin
                n_fail++;
                $display("FAIL pulse3 e%0d: rise=%b fall=%b level=%b want %b %b %b",
                         i, rise, fall, level, (i == 5), (i == 8), (i >= 5 && i < 8));
            end
        end
        n_checks++;
        if (rise_cnt !== 8'd1 || fall_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL pulse3_counts: got %0d/%0d want 1/1", rise_cnt, fall_cnt);
        end
    endtask

    task automatic test_saturation();
        reset_dut();
        for (int p = 1; p <= 9; p++) begin
            for (int i = 0; i < 12; i++) begin
                d = (i < 6);
                tick();
            end
            if (p == 7) begin
                n_checks++;
                if (rise_cnt_s !== 3'd7 || fall_cnt_s !== 3'd7 || ovf_s !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sat_at_max: got %0d/%0d ovf=%b want 7/7 ovf=0",
                             rise_cnt_s, fall_cnt_s, ovf_s);
                end
            end
        end
        n_checks++;
        if (rise_cnt_s !== 3'd7 || fall_cnt_s !== 3'd7 || ovf_s !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d/%0d ovf=%b want 7/7 ovf=1", rise_cnt_s, fall_cnt_s, ovf_s);
        end
        n_checks++;
        if (rise_cnt !== 8'd9 || fall_cnt !== 8'd9 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_counts: got %0d/%0d ovf=%b want 9/9 ovf=0", rise_cnt, fall_cnt, ovf);
        end
        // Bring the level high so the clear can be seen to leave it alone.
        d = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (rise_cnt_s !== 3'd0 || fall_cnt_s !== 3'd0 || ovf_s !== 1'b0 || level_s !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_clr: got %0d/%0d ovf=%b level=%b want 0/0 ovf=0 level=1",
                     rise_cnt_s, fall_cnt_s, ovf_s, level_s);
        end
    endtask

    task automatic test_clr_coincident();
        reset_dut();
        for (int i = 1; i <= 5; i++) begin
            d   = 1'b1;
            clr = (i == 5);
            tick();
        end
        clr = 1'b0;
        n_checks++;
        if (rise !== 1'b1 || rise_cnt !== 8'd0 || level !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_rise_edge: rise=%b cnt=%0d level=%b want 1 0 1", rise, rise_cnt, level);
        end
        tick();
        n_checks++;
        if (rise !== 1'b0 || rise_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL clr_rise_after: rise=%b cnt=%0d want 0 0", rise, rise_cnt);
        end
    endtask

    task automatic test_reset_mid_pending();
        reset_dut();
        // Three edges with d high leave the filter in HIGH_PEND with fc = 1.
        d = 1'b1;
        tick(); tick(); tick();
        rst = 1'b1; d = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_checks++;
            if (rise !== 1'b0 || level !== 1'b0 || rise_cnt !== 8'd0 || fall_cnt !== 8'd0) begin
                n_fail++;
                $display("FAIL mid_pending e%0d: rise=%b level=%b cnt=%0d/%0d want 0 0 0/0",
                         i, rise, level, rise_cnt, fall_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_toggle();
        test_glitch_filter();
        test_saturation();
        test_clr_coincident();
        test_reset_mid_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
